id_stage_p: RTL

ID_STAGE_P -- requirements
Module: id_stage_p

---
 rtl/id_stage_p.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_p.sv
// ---------------------------------------------------------------------------
// id_stage_p : MIPS-style instruction decode stage.
//
// Holds the IF/ID pipeline register, keeps the fetched instruction stable
// while IF is stopped, resolves source operands (forwarding or regfile),
// raises the load-use / RAW interlock request and resolves branches and
// jumps in ID.
//
// Build option:
//   ID_STAGE_P_FWD_EN  defined   -> operands forwarded from fwd_bus, interlock
//                                   only on a load in port 0 (EX).
//                      undefined -> operands straight from the regfile,
//                                   interlock on any pending write to a used
//                                   source register.
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   stall[STALL_W]   stall vector, bit 1 = IF/ID, bit 2 = ID/EX, 1 = stop
//   flush            discard IF/ID contents
//   if_to_id_bus     {ce, pc[31:0]} from IF
//   inst_sram_rdata  instruction, valid one cycle after IF issue
//   fwd_bus          per port k at [39k+38:39k]: {we, is_load, waddr, wdata}
//   rf_raddr1/2      regfile read addresses (rs / rt)
//   rf_rdata1/2      regfile read data
//   id_valid/id_pc   registered ce / pc
//   id_inst          instruction in ID (0 for a bubble)
//   rs_data/rt_data  resolved operands
//   stallreq         interlock request (combinational)
//   br_bus           {br_e, br_addr[31:0]}
//   id_state         RUN=0, HOLD=1, INTERLOCK=2
// ---------------------------------------------------------------------------
module id_stage_p #(
   parameter int NUM_FWD = 3,
   parameter int STALL_W = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STALL_W-1:0]     stall,
   input  logic                   flush,
   input  logic [32:0]            if_to_id_bus,
   input  logic [31:0]            inst_sram_rdata,
   input  logic [NUM_FWD*39-1:0]  fwd_bus,
   output logic [4:0]             rf_raddr1,
   output logic [4:0]             rf_raddr2,
   input  logic [31:0]            rf_rdata1,
   input  logic [31:0]            rf_rdata2,
   output logic                   id_valid,
   output logic [31:0]            id_pc,
   output logic [31:0]            id_inst,
   output logic [31:0]            rs_data,
   output logic [31:0]            rt_data,
   output logic                   stallreq,
   output logic [32:0]            br_bus,
   output logic [1:0]             id_state
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HOLD      = 2'd1,
      INTERLOCK = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic        is_load;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } fwd_port_t;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] FN_JR      = 6'b001000;

   logic        ifid_ce;
   logic [31:0] ifid_pc;
   logic        hold_v;
   logic [31:0] hold_r;
   state_t      state_q, state_d;

   logic        if_stop, ex_stop;
   assign if_stop = stall[1];
   assign ex_stop = stall[2];

   // -------------------------------------------------------------------------
   // IF/ID register. Flush wins over everything; IF stopped with ID/EX
   // running means ID must drain, so a bubble goes in.
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_ce <= 1'b0;
         ifid_pc <= 32'h0;
      end else if (flush || (if_stop && !ex_stop)) begin
         ifid_ce <= 1'b0;
         ifid_pc <= 32'h0;
      end else if (!if_stop) begin
         ifid_ce <= if_to_id_bus[32];
         ifid_pc <= if_to_id_bus[31:0];
      end
   end

   // The SRAM only presents the word for one cycle; capture it on the first
   // stopped cycle so ID keeps seeing the same instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v <= 1'b0;
         hold_r <= 32'h0;
      end else if (flush || !if_stop) begin
         hold_v <= 1'b0;
      end else if (!hold_v) begin
         hold_v <= 1'b1;
         hold_r <= inst_sram_rdata;
      end
   end

   assign id_valid = ifid_ce;
   assign id_pc    = ifid_pc;
   assign id_inst  = !ifid_ce ? 32'h0 : (hold_v ? hold_r : inst_sram_rdata);

   // -------------------------------------------------------------------------
   // Decode
   // -------------------------------------------------------------------------
   logic [5:0] opcode, funct;
   logic [4:0] rs_addr, rt_addr;
   logic       rs_used, rt_used;

   assign opcode    = id_inst[31:26];
   assign funct     = id_inst[5:0];
   assign rs_addr   = id_inst[25:21];
   assign rt_addr   = id_inst[20:16];
   assign rf_raddr1 = rs_addr;
   assign rf_raddr2 = rt_addr;

   assign rs_used = !(opcode == OP_J || opcode == OP_JAL || opcode == OP_LUI);
   assign rt_used = (opcode == OP_SPECIAL) || (opcode == OP_BEQ) ||
                    (opcode == OP_BNE) || (opcode[5:3] == 3'b101);

   // -------------------------------------------------------------------------
   // Operand resolution and interlock
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      fwd_port_t p;
      p       = '0;
      rs_data = rf_rdata1;
      rt_data = rf_rdata2;
`ifdef ID_STAGE_P_FWD_EN
      // Walk from the farthest port down so the nearest matching port wins.
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         p = fwd_port_t'(fwd_bus[39*k +: 39]);
         if (p.we && p.waddr == rs_addr) rs_data = p.wdata;
         if (p.we && p.waddr == rt_addr) rt_data = p.wdata;
      end
      if (rs_addr == 5'd0) rs_data = 32'h0;
      if (rt_addr == 5'd0) rt_data = 32'h0;
`endif
   end

   always_comb begin
      fwd_port_t p;
      logic      hazard;
      hazard = 1'b0;
`ifdef ID_STAGE_P_FWD_EN
      // Only a load in EX cannot be forwarded in time.
      p = fwd_port_t'(fwd_bus[38:0]);
      if (p.we && p.is_load && p.waddr != 5'd0 &&
          ((rs_used && p.waddr == rs_addr) || (rt_used && p.waddr == rt_addr)))
         hazard = 1'b1;
`else
      p = '0;
      for (int k = 0; k < NUM_FWD; k++) begin
         p = fwd_port_t'(fwd_bus[39*k +: 39]);
         if (p.we && p.waddr != 5'd0 &&
             ((rs_used && p.waddr == rs_addr) || (rt_used && p.waddr == rt_addr)))
            hazard = 1'b1;
      end
`endif
      stallreq = ifid_ce && hazard;
   end

   // Folds the fields a given build does not look at (stall bits other than
   // 1/2, load flags, write data) so they are visibly consumed.
   logic unused_inputs;
   assign unused_inputs = ^{stall, fwd_bus};

   // -------------------------------------------------------------------------
   // Branch resolution
   // -------------------------------------------------------------------------
   logic [31:0] pc_plus4, br_offset, br_target;
   logic        br_take, br_e;

   assign pc_plus4  = ifid_pc + 32'd4;
   assign br_offset = {{14{id_inst[15]}}, id_inst[15:0], 2'b00};

   always_comb begin
      br_take   = 1'b0;
      br_target = 32'h0;
      unique case (opcode)
         OP_SPECIAL: if (funct == FN_JR) begin
            br_take   = 1'b1;
            br_target = rs_data;
         end
         OP_J, OP_JAL: begin
            br_take   = 1'b1;
            br_target = {pc_plus4[31:28], id_inst[25:0], 2'b00};
         end
         OP_BEQ: begin
            br_take   = (rs_data == rt_data);
            br_target = pc_plus4 + br_offset;
         end
         OP_BNE: begin
            br_take   = (rs_data != rt_data);
            br_target = pc_plus4 + br_offset;
         end
         default: ;
      endcase
   end

   // Operands are not trustworthy while interlocked, so no redirect then.
   assign br_e   = ifid_ce && !stallreq && br_take;
   assign br_bus = {br_e, br_e ? br_target : 32'h0};

   // -------------------------------------------------------------------------
   // Stage status FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               if (stallreq)     state_d = INTERLOCK;
               else if (if_stop) state_d = HOLD;
            end
            HOLD:      if (!if_stop)  state_d = RUN;
            INTERLOCK: if (!stallreq) state_d = RUN;
            default:   state_d = RUN;
         endcase
      end
   end

   assign id_state = state_q;

endmodule
